// File: rtl/sap2_pkg.sv
// Shared definitions for the SAP-2 slow-clock path: debounce FSM state encoding.
package sap2_pkg;

    typedef logic [1:0] dbnc_state_t;

    localparam dbnc_state_t IDLE        = 2'd0;
    localparam dbnc_state_t PRESS_CHK   = 2'd1;
    localparam dbnc_state_t HELD        = 2'd2;
    localparam dbnc_state_t RELEASE_CHK = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Turns divided-clock rises (auto) or debounced button presses (manual) into a one-cycle
// CPU clock-enable strobe, with halt gating and a wrapping step counter.
module step_pulse_gen
    import sap2_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             slow_clk,
    input  logic             step_btn,
    input  logic             manual,
    input  logic             hlt,
    output logic             step,
    output logic [CNT_W-1:0] step_count,
    output logic             running
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            slow_s;
    logic            btn_s;
    logic            slow_prev;
    logic            manual_prev;
    dbnc_state_t     state;
    logic [DB_W-1:0] cnt;
    logic            mode_change;
    logic            press_done;
    logic            step_next;

    sync_2ff u_sync_slow (
        .clk   (clk_in),
        .rst_n (rst_n),
        .din   (slow_clk),
        .dout  (slow_s)
    );

    sync_2ff u_sync_btn (
        .clk   (clk_in),
        .rst_n (rst_n),
        .din   (step_btn),
        .dout  (btn_s)
    );

    assign mode_change = (manual != manual_prev);
    assign press_done  = (state == PRESS_CHK) && btn_s && (cnt == CNT_LAST);

    // Halt and mode changes drop the event outright; nothing is queued for later.
    always_comb begin
        step_next = 1'b0;
        if (!mode_change && !hlt) begin
            if (manual) begin
                step_next = press_done;
            end else begin
                step_next = slow_s && !slow_prev;
            end
        end
    end

    // Debounce FSM runs in both modes so a mode switch always starts it from a clean IDLE.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (mode_change) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        cnt   <= '0;
                        state <= PRESS_CHK;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_s) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        cnt   <= '0;
                        state <= RELEASE_CHK;
                    end
                end
                RELEASE_CHK: begin
                    if (btn_s) begin
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + DB_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            slow_prev   <= 1'b0;
            manual_prev <= 1'b0;
            step        <= 1'b0;
            step_count  <= '0;
            running     <= 1'b0;
        end else begin
            slow_prev   <= slow_s;
            manual_prev <= manual;
            step        <= step_next;
            step_count  <= step_count + CNT_W'(step_next);
            running     <= !hlt;
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed and randomized bench for step_pulse_gen against an event-level reference model.
module tb_step_pulse_gen;

    localparam int DB  = 4;
    localparam int CW  = 4;

    logic          clk_in = 1'b0;
    logic          rst_n;
    logic          slow_clk;
    logic          step_btn;
    logic          manual;
    logic          hlt;
    logic          step;
    logic [CW-1:0] step_count;
    logic          running;

    int tests_run    = 0;
    int tests_failed = 0;
    int steps_seen   = 0;
    int btn_left     = 0;
    int slow_left    = 0;

    // Reference model state: input pipelines, a press/release run-length tracker and outputs.
    logic m_slow_q1, m_slow_q2, m_btn_q1, m_btn_q2;
    logic m_slow_prev, m_manual_prev, m_armed;
    logic m_slow_s, m_btn_s, m_rise, m_mchg, m_press;
    int   m_run;
    logic m_step, m_running;
    int   m_count;

    step_pulse_gen #(
        .DEBOUNCE_CYCLES (DB),
        .CNT_W           (CW)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .slow_clk   (slow_clk),
        .step_btn   (step_btn),
        .manual     (manual),
        .hlt        (hlt),
        .step       (step),
        .step_count (step_count),
        .running    (running)
    );

    always #5 clk_in = ~clk_in;

    // A press is accepted after DB+1 consecutive high samples while armed; re-arming needs
    // DB+1 consecutive low samples. Inputs reach the logic two samples late.
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_slow_q1 = 0; m_slow_q2 = 0; m_btn_q1 = 0; m_btn_q2 = 0;
            m_slow_prev = 0; m_manual_prev = 0; m_armed = 1; m_run = 0;
            m_step = 0; m_running = 0; m_count = 0;
        end else begin
            m_slow_s  = m_slow_q2;
            m_slow_q2 = m_slow_q1;
            m_slow_q1 = slow_clk;
            m_btn_s   = m_btn_q2;
            m_btn_q2  = m_btn_q1;
            m_btn_q1  = step_btn;
            m_rise      = m_slow_s && !m_slow_prev;
            m_slow_prev = m_slow_s;
            m_mchg        = (manual != m_manual_prev);
            m_manual_prev = manual;
            m_press = 0;
            if (m_mchg) begin
                m_armed = 1;
                m_run   = 0;
            end else if (m_armed) begin
                m_run = m_btn_s ? m_run + 1 : 0;
                if (m_run == DB + 1) begin
                    m_press = 1;
                    m_armed = 0;
                    m_run   = 0;
                end
            end else begin
                m_run = !m_btn_s ? m_run + 1 : 0;
                if (m_run == DB + 1) begin
                    m_armed = 1;
                    m_run   = 0;
                end
            end
            m_step    = !m_mchg && !hlt && (manual ? m_press : m_rise);
            m_count   = m_step ? (m_count + 1) % (1 << CW) : m_count;
            m_running = !hlt;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("step", 16'(step), 16'(m_step));
        check("step_count", 16'(step_count), 16'(m_count));
        check("running", 16'(running), 16'(m_running));
        if (step === 1'b1) steps_seen++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk_in);
            check_output();
        end
    endtask

    initial begin
        rst_n = 1'b0; slow_clk = 1'b0; step_btn = 1'b0; manual = 1'b0; hlt = 1'b0;
        tick(3);
        check("reset_step", 16'(step), 16'd0);
        check("reset_count", 16'(step_count), 16'd0);
        rst_n = 1'b1;

        // Auto mode: five rises of a divided clock toggling every 10 cycles.
        repeat (5) begin
            slow_clk = 1'b1; tick(10);
            slow_clk = 1'b0; tick(10);
        end
        check("auto_five_rises", 16'(step_count), 16'd5);

        // Manual: bouncy press, bouncy release, clean second press.
        manual = 1'b1; tick(6);
        step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(1);
        step_btn = 1'b1; tick(1); step_btn = 1'b0; tick(1);
        step_btn = 1'b1; tick(20);
        step_btn = 1'b0; tick(1); step_btn = 1'b1; tick(1);
        step_btn = 1'b0; tick(20);
        step_btn = 1'b1; tick(20);
        step_btn = 1'b0; tick(20);
        check("manual_two_presses", 16'(step_count), 16'd7);

        step_btn = 1'b1; tick(100);
        step_btn = 1'b0; tick(20);
        check("long_hold_one_step", 16'(step_count), 16'd8);

        // Halt across three rises, then the first rise after release steps.
        manual = 1'b0; tick(5);
        hlt = 1'b1;
        repeat (3) begin
            slow_clk = 1'b1; tick(10);
            slow_clk = 1'b0; tick(10);
        end
        check("halt_frozen", 16'(step_count), 16'd8);
        hlt = 1'b0; tick(2);
        slow_clk = 1'b1; tick(10);
        slow_clk = 1'b0; tick(10);
        check("after_halt", 16'(step_count), 16'd9);

        // Mode switch landing on the synchronised rise, then switch with slow_s already high.
        manual = 1'b1; tick(5);
        slow_clk = 1'b1; tick(2);
        manual = 1'b0; tick(10);
        slow_clk = 1'b0; tick(10);
        manual = 1'b1; tick(3);
        slow_clk = 1'b1; tick(5);
        manual = 1'b0; tick(10);
        slow_clk = 1'b0; tick(10);
        check("mode_switch_no_step", 16'(step_count), 16'd9);

        // Switching away during a press check abandons it.
        manual = 1'b1; tick(3);
        step_btn = 1'b1; tick(4);
        manual = 1'b0; tick(3);
        step_btn = 1'b0; tick(10);
        manual = 1'b1; tick(10);
        check("switch_in_press_chk", 16'(step_count), 16'd9);

        // Randomized traffic on every input.
        for (int i = 0; i < 400; i++) begin
            if (btn_left == 0) begin
                step_btn = !step_btn;
                btn_left = int'($urandom_range(1, 12));
            end else begin
                btn_left--;
            end
            if (slow_left == 0) begin
                slow_clk  = !slow_clk;
                slow_left = int'($urandom_range(2, 10));
            end else begin
                slow_left--;
            end
            if ($urandom_range(0, 49) == 0) manual = !manual;
            if ($urandom_range(0, 29) == 0) hlt = !hlt;
            tick(1);
        end
        hlt = 1'b0; step_btn = 1'b0; slow_clk = 1'b0; manual = 1'b1;
        tick(20);

        // Reset asserted mid-press clears outputs at once and leaves no pulse behind.
        step_btn = 1'b1; tick(4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_step", 16'(step), 16'd0);
        check("rst_async_count", 16'(step_count), 16'd0);
        check("rst_async_running", 16'(running), 16'd0);
        step_btn = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("no_pulse_after_reset", 16'(step_count), 16'd0);

        // Sixteen steps wrap the 4-bit counter back to zero.
        manual = 1'b0; tick(3);
        steps_seen = 0;
        repeat (16) begin
            slow_clk = 1'b1; tick(4);
            slow_clk = 1'b0; tick(4);
        end
        tick(4);
        check("wrap_count", 16'(step_count), 16'd0);
        check("wrap_steps_seen", 16'(steps_seen), 16'd16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
